redmule_cfg_builder: RTL

REDMULE_CFG_BUILDER -- requirements
Module: redmule_cfg_builder

---
 rtl/redmule_pkg.sv | 88 ++++++++
 rtl/redmule_seq_mul.sv | 67 ++++++
 rtl/redmule_cfg_builder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_pkg.sv
`default_nettype none
// ============================================================================
// Module      : redmule_pkg
// Description : Shared types and array geometry for the RedMulE datapath and
//               its job-configuration front end.
// Revision    : 1.0 - initial release
// ============================================================================
package redmule_pkg;

    localparam int unsigned ARRAY_WIDTH  = 4;
    localparam int unsigned ARRAY_HEIGHT = 4;
    localparam int unsigned PIPE_REGS    = 1;

    // Round-to-nearest-even encoding of the FPU rounding-mode field
    localparam logic [2:0] RNE = 3'b000;

    typedef enum logic [2:0] {
        MATMUL = 3'd0,
        GEMM   = 3'd1,
        ADDMAX = 3'd2,
        ADDMIN = 3'd3,
        MULMAX = 3'd4,
        MULMIN = 3'd5,
        MAXMIN = 3'd6,
        MINMAX = 3'd7
    } gemm_op_e;

    typedef enum logic [1:0] {
        Float8     = 2'd0,
        Float16    = 2'd1,
        Float8Alt  = 2'd2,
        Float16Alt = 2'd3
    } gemm_fmt_e;

    typedef enum logic [1:0] {
        FPU_FMADD  = 2'd0,
        FPU_ADD    = 2'd1,
        FPU_MUL    = 2'd2,
        FPU_MINMAX = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        FP8     = 2'd0,
        FP16    = 2'd1,
        FP8ALT  = 2'd2,
        FP16ALT = 2'd3
    } fpu_fmt_e;

    typedef struct packed {
        logic [31:0] x_addr;
        logic [31:0] w_addr;
        logic [31:0] z_addr;
        logic [15:0] m_size;
        logic [15:0] n_size;
        logic [15:0] k_size;
        logic [15:0] x_rows_iter;
        logic [7:0]  x_rows_lftovr;
        logic [15:0] x_cols_iter;
        logic [7:0]  x_cols_lftovr;
        logic [15:0] w_rows_iter;
        logic [7:0]  w_rows_lftovr;
        logic [15:0] w_cols_iter;
        logic [7:0]  w_cols_lftovr;
        logic [31:0] x_d1_stride;
        logic [31:0] w_d0_stride;
        logic [31:0] yz_d0_stride;
        logic [31:0] x_rows_offs;
        logic [31:0] yz_d2_stride;
        logic [15:0] tot_stores;
        logic [31:0] yz_tot_len;
        logic [31:0] x_tot_len;
        logic [31:0] w_tot_len;
        logic [31:0] tot_x_read;
        logic [31:0] x_buffer_slots;
        gemm_op_e    gemm_ops;
        gemm_fmt_e   gemm_input_fmt;
        gemm_fmt_e   gemm_output_fmt;
        fpu_op_e     stage_1_op;
        fpu_op_e     stage_2_op;
        logic [2:0]  stage_1_rnd;
        logic [2:0]  stage_2_rnd;
        fpu_fmt_e    input_format;
        fpu_fmt_e    computing_format;
        logic        gemm_selection;
    } redmule_config_t;

endpackage
`default_nettype wire

// File: rtl/redmule_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : redmule_seq_mul
// Description : 16x16 -> 32 sequential shift-add multiplier. One partial
//               product per cycle; the first one is taken straight from the
//               operand inputs in the start cycle, so the result is presented
//               (product_o valid while done_o is high) in the 16th cycle.
// Ports       : clk_i, rst_i     clock / sync active-high reset
//               start_i          begin a multiply with a_i, b_i (when idle)
//               a_i, b_i         16-bit operands
//               busy_o           multiply in progress
//               done_o           product_o holds the final product this cycle
//               product_o        32-bit product
// Revision    : 1.0 - initial release
// ============================================================================
module redmule_seq_mul (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);

    logic        r_busy;
    logic [3:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [15:0] r_mplier;

    logic [31:0] w_acc;
    logic [31:0] w_mcand;
    logic [15:0] w_mplier;
    logic [31:0] w_sum;

    // In the start cycle the step operates on the raw inputs
    always_comb begin
        w_acc    = start_i ? 32'd0 : r_acc;
        w_mcand  = start_i ? {16'd0, a_i} : r_mcand;
        w_mplier = start_i ? b_i : r_mplier;
        w_sum    = w_acc + (w_mplier[0] ? w_mcand : 32'd0);
    end

    assign busy_o    = r_busy;
    assign done_o    = r_busy && (r_cnt == 4'd15);
    assign product_o = w_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy   <= 1'b0;
            r_cnt    <= 4'd0;
            r_acc    <= 32'd0;
            r_mcand  <= 32'd0;
            r_mplier <= 16'd0;
        end else if (start_i || r_busy) begin
            r_acc    <= w_sum;
            r_mcand  <= w_mcand << 1;
            r_mplier <= w_mplier >> 1;
            r_cnt    <= start_i ? 4'd1 : r_cnt + 4'd1;
            r_busy   <= start_i ? 1'b1 : (r_cnt != 4'd15);
        end
    end

endmodule
`default_nettype wire

// File: rtl/redmule_cfg_builder.sv
`default_nettype none
// ============================================================================
// Module      : redmule_cfg_builder
// Description : Turns a raw GEMM job (addresses, M/N/K sizes, op, formats)
//               into the full RedMulE configuration. Divisions are power-of-
//               two shifts/masks done in one cycle; the three products share
//               one 16-cycle sequential multiplier. Zero-sized jobs are
//               rejected immediately with err_o and an all-zero config.
// Ports       : clk_i, rst_i                  clock / sync active-high reset
//               start_valid_i / start_ready_o job handshake (ready in IDLE)
//               x/w/z_addr_i, m/n/k_size_i    job operands
//               gemm_op_i, in_fmt_i, out_fmt_i operation and formats
//               cfg_o, cfg_valid_o/cfg_ready_i derived config + handshake
//               err_o                         job rejected (with cfg_valid_o)
//               busy_o                        FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module redmule_cfg_builder
    import redmule_pkg::*;
#(
    parameter int unsigned ARRAY_WIDTH  = redmule_pkg::ARRAY_WIDTH,
    parameter int unsigned ARRAY_HEIGHT = redmule_pkg::ARRAY_HEIGHT,
    parameter int unsigned TILE         = (redmule_pkg::PIPE_REGS + 1) * ARRAY_HEIGHT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_valid_i,
    output logic            start_ready_o,
    input  logic [31:0]     x_addr_i,
    input  logic [31:0]     w_addr_i,
    input  logic [31:0]     z_addr_i,
    input  logic [15:0]     m_size_i,
    input  logic [15:0]     n_size_i,
    input  logic [15:0]     k_size_i,
    input  gemm_op_e        gemm_op_i,
    input  gemm_fmt_e       in_fmt_i,
    input  gemm_fmt_e       out_fmt_i,
    output redmule_config_t cfg_o,
    output logic            cfg_valid_o,
    input  logic            cfg_ready_i,
    output logic            err_o,
    output logic            busy_o
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_DIV  = 3'd1;
    localparam logic [2:0] c_MUL0 = 3'd2;
    localparam logic [2:0] c_MUL1 = 3'd3;
    localparam logic [2:0] c_MUL2 = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    localparam logic [4:0]  c_aw_sh   = 5'($clog2(ARRAY_WIDTH));
    localparam logic [4:0]  c_ah_sh   = 5'($clog2(ARRAY_HEIGHT));
    localparam logic [4:0]  c_tile_sh = 5'($clog2(TILE));
    localparam logic [15:0] c_aw_msk  = 16'(ARRAY_WIDTH - 1);
    localparam logic [15:0] c_ah_msk  = 16'(ARRAY_HEIGHT - 1);
    localparam logic [15:0] c_tile_msk = 16'(TILE - 1);

    logic [2:0]      r_state;
    logic [31:0]     r_x_addr, r_w_addr, r_z_addr;
    logic [15:0]     r_m, r_n, r_k;
    gemm_op_e        r_op;
    gemm_fmt_e       r_in_fmt, r_out_fmt;
    logic [15:0]     r_p0_lo;
    logic            r_err;
    redmule_config_t r_cfg;

    redmule_config_t w_div_cfg;
    logic [15:0]     w_m_rem, w_n_tile_rem, w_n_ah_rem, w_k_tile_rem;
    logic [4:0]      w_ein_sh, w_eout_sh;
    logic [15:0]     w_mul_a, w_mul_b;
    logic            w_in_mul, w_mul_start, w_mul_busy, w_mul_done;
    logic [31:0]     w_mul_p;

    // log2 of the element size in bytes
    function automatic logic [4:0] elem_shift(input gemm_fmt_e fmt);
        return (fmt == Float16 || fmt == Float16Alt) ? 5'd1 : 5'd0;
    endfunction

    function automatic fpu_fmt_e to_fpu_fmt(input gemm_fmt_e fmt);
        case (fmt)
            Float16:    return FP16;
            Float8Alt:  return FP8ALT;
            Float16Alt: return FP16ALT;
            default:    return FP8;
        endcase
    endfunction

    // ---------------- single-cycle divide/stride stage ----------------
    always_comb begin
        w_m_rem      = r_m & c_aw_msk;
        w_n_tile_rem = r_n & c_tile_msk;
        w_n_ah_rem   = r_n & c_ah_msk;
        w_k_tile_rem = r_k & c_tile_msk;
        w_ein_sh     = elem_shift(r_in_fmt);
        w_eout_sh    = elem_shift(r_out_fmt);

        w_div_cfg        = '0;
        w_div_cfg.x_addr = r_x_addr;
        w_div_cfg.w_addr = r_w_addr;
        w_div_cfg.z_addr = r_z_addr;
        w_div_cfg.m_size = r_m;
        w_div_cfg.n_size = r_n;
        w_div_cfg.k_size = r_k;

        // ceil(a / 2^s) = (a >> s) + (any remainder bit set)
        w_div_cfg.x_rows_iter   = (r_m >> c_aw_sh)   + {15'd0, |w_m_rem};
        w_div_cfg.x_rows_lftovr = w_m_rem[7:0];
        w_div_cfg.x_cols_iter   = (r_n >> c_tile_sh) + {15'd0, |w_n_tile_rem};
        w_div_cfg.x_cols_lftovr = w_n_tile_rem[7:0];
        w_div_cfg.w_rows_iter   = (r_n >> c_ah_sh)   + {15'd0, |w_n_ah_rem};
        w_div_cfg.w_rows_lftovr = w_n_ah_rem[7:0];
        w_div_cfg.w_cols_iter   = (r_k >> c_tile_sh) + {15'd0, |w_k_tile_rem};
        w_div_cfg.w_cols_lftovr = w_k_tile_rem[7:0];

        w_div_cfg.x_d1_stride  = {16'd0, r_n} << w_ein_sh;
        w_div_cfg.w_d0_stride  = {16'd0, r_k} << w_ein_sh;
        w_div_cfg.yz_d0_stride = {16'd0, r_k} << w_eout_sh;
        w_div_cfg.x_rows_offs  = {16'd0, r_n} << (w_ein_sh + c_aw_sh);
        w_div_cfg.yz_d2_stride = {16'd0, r_k} << (w_eout_sh + c_aw_sh);

        w_div_cfg.x_buffer_slots = {16'd0, w_div_cfg.x_cols_iter};

        w_div_cfg.gemm_ops        = r_op;
        w_div_cfg.gemm_input_fmt  = r_in_fmt;
        w_div_cfg.gemm_output_fmt = r_out_fmt;
        case (r_op)
            MATMUL, GEMM: begin
                w_div_cfg.stage_1_op = FPU_FMADD;
                w_div_cfg.stage_2_op = FPU_FMADD;
            end
            ADDMAX, ADDMIN: begin
                w_div_cfg.stage_1_op = FPU_ADD;
                w_div_cfg.stage_2_op = FPU_MINMAX;
            end
            MULMAX, MULMIN: begin
                w_div_cfg.stage_1_op = FPU_MUL;
                w_div_cfg.stage_2_op = FPU_MINMAX;
            end
            default: begin
                w_div_cfg.stage_1_op = FPU_MINMAX;
                w_div_cfg.stage_2_op = FPU_MINMAX;
            end
        endcase
        w_div_cfg.stage_1_rnd      = RNE;
        w_div_cfg.stage_2_rnd      = RNE;
        w_div_cfg.input_format     = to_fpu_fmt(r_in_fmt);
        w_div_cfg.computing_format = to_fpu_fmt(r_in_fmt);
        w_div_cfg.gemm_selection   = (r_op == GEMM);
    end

    // ---------------- shared multiplier operand select ----------------
    always_comb begin
        w_mul_a = 16'd0;
        w_mul_b = 16'd0;
        case (r_state)
            c_MUL0: begin
                w_mul_a = r_cfg.x_rows_iter;
                w_mul_b = r_cfg.w_cols_iter;
            end
            c_MUL1: begin
                w_mul_a = r_p0_lo;
                w_mul_b = r_cfg.x_cols_iter;
            end
            c_MUL2: begin
                w_mul_a = r_p0_lo;
                w_mul_b = r_n;
            end
            default: ;
        endcase
    end

    assign w_in_mul    = (r_state == c_MUL0) || (r_state == c_MUL1) || (r_state == c_MUL2);
    // Each MUL state kicks the multiplier in its first cycle, while it is idle
    assign w_mul_start = w_in_mul && !w_mul_busy;

    redmule_seq_mul u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_mul_start),
        .a_i       (w_mul_a),
        .b_i       (w_mul_b),
        .busy_o    (w_mul_busy),
        .done_o    (w_mul_done),
        .product_o (w_mul_p)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_IDLE;
            r_x_addr  <= 32'd0;
            r_w_addr  <= 32'd0;
            r_z_addr  <= 32'd0;
            r_m       <= 16'd0;
            r_n       <= 16'd0;
            r_k       <= 16'd0;
            r_op      <= MATMUL;
            r_in_fmt  <= Float8;
            r_out_fmt <= Float8;
            r_p0_lo   <= 16'd0;
            r_err     <= 1'b0;
            r_cfg     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_valid_i) begin
                        r_x_addr  <= x_addr_i;
                        r_w_addr  <= w_addr_i;
                        r_z_addr  <= z_addr_i;
                        r_m       <= m_size_i;
                        r_n       <= n_size_i;
                        r_k       <= k_size_i;
                        r_op      <= gemm_op_i;
                        r_in_fmt  <= in_fmt_i;
                        r_out_fmt <= out_fmt_i;
                        if (m_size_i == 16'd0 || n_size_i == 16'd0 || k_size_i == 16'd0) begin
                            r_err   <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_DIV;
                        end
                    end
                end
                c_DIV: begin
                    r_cfg   <= w_div_cfg;
                    r_state <= c_MUL0;
                end
                c_MUL0: begin
                    if (w_mul_done) begin
                        r_p0_lo          <= w_mul_p[15:0];
                        r_cfg.tot_stores <= w_mul_p[15:0];
                        r_cfg.yz_tot_len <= w_mul_p << c_aw_sh;
                        r_state          <= c_MUL1;
                    end
                end
                c_MUL1: begin
                    if (w_mul_done) begin
                        r_cfg.x_tot_len  <= w_mul_p;
                        r_cfg.tot_x_read <= w_mul_p;
                        r_state          <= c_MUL2;
                    end
                end
                c_MUL2: begin
                    if (w_mul_done) begin
                        r_cfg.w_tot_len <= w_mul_p;
                        r_state         <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (cfg_ready_i) begin
                        r_err   <= 1'b0;
                        r_cfg   <= '0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign start_ready_o = (r_state == c_IDLE);
    assign cfg_valid_o   = (r_state == c_DONE);
    assign busy_o        = (r_state != c_IDLE);
    assign err_o         = r_err;
    assign cfg_o         = r_cfg;

endmodule
`default_nettype wire
